// File: rtl/data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared definitions for the two-master data-memory arbiter:
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   own_state_t             : ownership state encoding (FREE, OWN0, OWN1)
//   LOCK_MAX / CNT_W        : lock starvation limit and its counter width
// -----------------------------------------------------------------------------
package data_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;

  // A locked master may hold the memory for at most this many consecutive grants.
  localparam int LOCK_MAX = 16;
  localparam int CNT_W    = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } own_state_t;

endpackage

// File: rtl/data_mem_arbiter_rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
// Two-requester grant logic with a last-grant pointer, lock ownership and a
// lock starvation counter. The grant is combinational (zero-cycle latency).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_req[1:0]   : request per master
//   i_lock[1:0]  : keep-ownership request per master
//   o_gnt[1:0]   : one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_grant2
  import data_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_gnt
);

  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  own_state_t       r_state, w_state_next;
  logic             r_ptr, w_ptr_next;      // master that received the last grant
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_any;
  logic             w_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FREE;
      r_ptr   <= 1'b1;                      // master 0 wins the first tie
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Grant selection
  always_comb begin
    o_gnt = 2'b00;
    case (r_state)
      ST_OWN0: o_gnt[0] = i_req[0];
      ST_OWN1: o_gnt[1] = i_req[1];
      default: begin
        if (i_req == 2'b11) o_gnt[~r_ptr] = 1'b1;
        else                o_gnt = i_req;
      end
    endcase
  end

  assign w_any = |o_gnt;
  assign w_sel = o_gnt[1];

  // Next ownership state, pointer and lock counter
  always_comb begin
    w_state_next = ST_FREE;
    w_ptr_next   = r_ptr;
    w_cnt_next   = '0;
    w_cnt_inc    = '0;
    if (w_any) begin
      w_ptr_next = w_sel;
      if (i_lock[w_sel]) begin
        // The grant that takes ownership from FREE is the first of the run.
        w_cnt_inc = (r_state == ST_FREE) ? CNT_W'(1) : CNT_W'(r_cnt + 1'b1);
        if (w_cnt_inc >= LOCK_MAX_C) begin
          // Forced release; the pointer already names this master, so the
          // other master wins the next tie.
          w_state_next = ST_FREE;
          w_cnt_next   = '0;
        end else begin
          w_state_next = w_sel ? ST_OWN1 : ST_OWN0;
          w_cnt_next   = w_cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Arbitrates a single-port data RAM between master 0 (CPU datapath) and
// master 1 (debug/loader). One access per cycle; read data returns one cycle
// after the grant as an rvalid pulse to the master that issued the read.
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   mX_req/wr/lock/addr/wdata          : master X request side
//   mX_gnt, mX_rdata, mX_rvalid        : master X response side
//   ram_rd, ram_wr, ram_addr, ram_wdata: RAM command
//   ram_rdata                          : RAM read data (one cycle after ram_rd)
// -----------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [1:0]        w_gnt_raw;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_sel;
  logic              w_wr;
  logic              r_rd_pending;
  logic              r_rd_owner;

  rr_grant2 u_rr_grant2 (
    .clk    (clk),
    .reset  (reset),
    .i_req  ({m1_req, m0_req}),
    .i_lock ({m1_lock, m0_lock}),
    .o_gnt  (w_gnt_raw)
  );

  // Grants are combinational from req, so they are masked while reset is high.
  assign w_gnt  = reset ? 2'b00 : w_gnt_raw;
  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];
  assign w_any  = |w_gnt;
  assign w_sel  = w_gnt[1];

  assign w_wr      = w_sel ? m1_wr : m0_wr;
  assign ram_rd    = w_any & ~w_wr;
  assign ram_wr    = w_any & w_wr;
  assign ram_addr  = w_any ? (w_sel ? m1_addr : m0_addr) : '0;
  assign ram_wdata = w_any ? (w_sel ? m1_wdata : m0_wdata) : '0;

  // Read-return pipeline: remembers who issued the read granted last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pending <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      r_rd_pending <= ram_rd;
      r_rd_owner   <= w_sel;
    end
  end

  assign m0_rvalid = r_rd_pending & ~r_rd_owner;
  assign m1_rvalid = r_rd_pending & r_rd_owner;
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with a behavioural RAM and a scoreboard
// of expected read returns.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_wr, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_wr, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          ram_rd, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int            due;
    logic          m;
    logic [DW-1:0] d;
  } exp_t;
  exp_t q[$];

  logic [DW-1:0] shadow [0:(1<<AW)-1];

  // Behavioural RAM
  logic [DW-1:0] ram_mem  [0:(1<<AW)-1];
  logic          ram_seen [0:(1<<AW)-1];

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 11'h005) return 16'h1234;
    return {5'h15, a} ^ 16'hC3A5;
  endfunction

  always @(posedge clk) begin
    if (ram_wr) begin
      ram_mem[ram_addr]  <= ram_wdata;
      ram_seen[ram_addr] <= 1'b1;
    end
    if (ram_rd)
      ram_rdata <= (ram_seen[ram_addr] === 1'b1) ? ram_mem[ram_addr] : init_val(ram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic w0, input logic l0,
                     input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, input logic w1, input logic l1,
                     input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_req = r0; m0_wr = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wr = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic drv_idle();
    drv(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk({tag, "_rdata"},  {m1_rdata, m0_rdata}, 32'd0);
    chk({tag, "_ramcmd"}, {30'd0, ram_wr, ram_rd}, 32'd0);
    chk({tag, "_ramaw"},  {5'd0, ram_addr, ram_wdata}, 32'd0);
  endtask

  // One cycle: inputs were driven just after a falling edge; check the
  // read return due this cycle, the grant and the RAM command, then record
  // the expected effect of the granted access.
  task automatic step(input logic [1:0] exp_g);
    logic          e0, e1;
    logic [DW-1:0] d0, d1;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    #1;
    e0 = 1'b0; e1 = 1'b0; d0 = '0; d1 = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].m) begin e1 = 1'b1; d1 = q[0].d; end
      else        begin e0 = 1'b1; d0 = q[0].d; end
      void'(q.pop_front());
    end
    chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, e0});
    chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, e1});
    chk("m0_rdata",  {16'd0, m0_rdata}, {16'd0, d0});
    chk("m1_rdata",  {16'd0, m1_rdata}, {16'd0, d1});
    chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, exp_g});
    ew = exp_g[1] ? m1_wr    : m0_wr;
    ea = exp_g[1] ? m1_addr  : (exp_g[0] ? m0_addr  : '0);
    ed = exp_g[1] ? m1_wdata : (exp_g[0] ? m0_wdata : '0);
    if (exp_g == 2'b00) ew = 1'b0;
    chk("ram_cmd", {30'd0, ram_wr, ram_rd},
        {30'd0, (exp_g != 2'b00) & ew, (exp_g != 2'b00) & ~ew});
    chk("ram_addr",  {21'd0, ram_addr}, {21'd0, ea});
    chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, ed});
    $display("cyc %0d: gnt=%b rv=%b%b rd0=%h rd1=%h ram_rd=%b ram_wr=%b addr=%h",
             cyc, {m1_gnt, m0_gnt}, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata,
             ram_rd, ram_wr, ram_addr);
    if (exp_g != 2'b00) begin
      if (ew) shadow[ea] = ed;
      else    q.push_back('{due: cyc + 1, m: exp_g[1], d: shadow[ea]});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    drv(1'b1, 1'b0, 1'b0, 11'h005, '0, 1'b1, 1'b0, 1'b0, 11'h006, '0);
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    drv_idle();
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(AW'(i));
    reset = 1'b1;
    drv_idle();
    @(negedge clk);

    // Reset state with requests present
    rst_pulse();

    // Single m0 read right after reset
    drv(1'b1, 1'b0, 1'b0, 11'h005, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(2'b01);
    drv_idle();
    step(2'b00);

    // Both masters write continuously: alternation starting with m0
    rst_pulse();
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b1, 1'b0, 11'h010, 16'hAAAA, 1'b1, 1'b1, 1'b0, 11'h020, 16'h5555);
      step((i % 2 == 0) ? 2'b01 : 2'b10);
    end
    drv(1'b1, 1'b0, 1'b0, 11'h010, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(2'b01);
    drv(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 11'h020, '0);
    step(2'b10);
    drv_idle();
    step(2'b00);

    // Lock starvation limit: m1 locked reads while m0 waits
    drv(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 11'h100, '0);
    step(2'b10);
    for (int i = 1; i < 16; i++) begin
      drv(1'b1, 1'b0, 1'b0, 11'h200, '0, 1'b1, 1'b0, 1'b1, AW'(11'h100 + i), '0);
      step(2'b10);
    end
    drv(1'b1, 1'b0, 1'b0, 11'h200, '0, 1'b1, 1'b0, 1'b1, 11'h110, '0);
    step(2'b01);
    for (int i = 16; i < 20; i++) begin
      drv(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, AW'(11'h100 + i), '0);
      step(2'b10);
    end
    drv_idle();
    step(2'b00);

    // Back-to-back reads at the address extremes, different masters
    drv(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 11'h7FF, '0);
    step(2'b10);
    drv(1'b1, 1'b0, 1'b0, 11'h000, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(2'b01);
    drv_idle();
    step(2'b00);

    // Reset asserted in the cycle an m0 read is granted
    drv(1'b1, 1'b0, 1'b0, 11'h033, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rg_gnt", {31'd0, m0_gnt}, 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("rg_assert");
    @(negedge clk);
    chk_all_zero("rg_held");
    drv_idle();
    reset = 1'b0;
    q.delete();
    step(2'b00);
    step(2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, data-memory address width.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m0_req  input  1  master 0 (CPU datapath) access request.
REQ-006 m0_wr  input  1  master 0 access type: 1 = write, 0 = read.
REQ-007 m0_lock  input  1  master 0 requests to keep ownership after the current access.
REQ-008 m0_addr  input  ADDR_W  master 0 word address.
REQ-009 m0_wdata  input  DATA_W  master 0 write data.
REQ-010 m0_gnt  output  1  master 0 access accepted this cycle.
REQ-011 m0_rdata  output  DATA_W  master 0 read data.
REQ-012 m0_rvalid  output  1  m0_rdata valid, one-cycle pulse.
REQ-013 m1_req, m1_wr, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid  same directions, widths and meanings for master 1 (debug/loader unit).
REQ-014 ram_rd  output  1  RAM read strobe.
REQ-015 ram_wr  output  1  RAM write strobe.
REQ-016 ram_addr  output  ADDR_W  RAM address.
REQ-017 ram_wdata  output  DATA_W  RAM write data.
REQ-018 ram_rdata  input  DATA_W  RAM read data, valid one cycle after ram_rd.

Function
REQ-019 Access handshake: a master holds req, wr, addr and wdata stable until it samples gnt=1; an access completes in any cycle with req=1 and gnt=1.
REQ-020 At most one gnt is asserted per cycle; gnt is combinational from req, the owner register and the round-robin pointer, with zero-cycle grant latency.
REQ-021 Ownership states: FREE, OWN0, OWN1 (registered).
REQ-022 In FREE: if only one master requests, that master is granted; if both request, the master not marked in the last-grant pointer is granted.
REQ-023 The last-grant pointer updates to the granted master on every completed access; its reset value is 1, so master 0 wins the first tie.
REQ-024 On a completed access with lock=1, the next state is OWNx for the granted master; with lock=0, the next state is FREE.
REQ-025 In OWNx, only master x may be granted; the other master's req is held off regardless of the pointer.
REQ-026 In OWNx, if master x deasserts req or lock, the next state is FREE; an OWNx cycle with req=1 and lock=0 still grants that access.
REQ-027 Lock starvation limit: an OWNx counter counts consecutive granted cycles; at 16 the next state is forced to FREE and the pointer favours the other master.
REQ-028 In the grant cycle, ram_rd = ~wr and ram_wr = wr; ram_addr and ram_wdata come from the granted master; with no grant, ram_rd = ram_wr = 0 and ram_addr/ram_wdata = 0.
REQ-029 A read grant sets a registered rd_pending flag and a registered rd_owner; in the next cycle the arbiter asserts rvalid for rd_owner only.
REQ-030 mX_rdata equals ram_rdata when mX_rvalid = 1, otherwise 0.
REQ-031 Back-to-back accesses are supported: a grant in cycle N+1 is allowed while the cycle-N read is returning; throughput is one access per cycle.
REQ-032 A write never produces rvalid.

Reset
REQ-033 Asynchronous assertion of reset forces: state FREE, pointer 1, lock counter 0, rd_pending 0, all gnt/rvalid/ram_rd/ram_wr outputs 0, all rdata outputs 0.
REQ-034 A read granted in the cycle reset asserts is discarded; no rvalid appears after reset deasserts.
REQ-035 The first grant may occur in the first rising edge after reset deasserts.

Structure
REQ-036 The shared package holds ADDR_W and DATA_W defaults, the ownership-state encoding, and LOCK_MAX = 16.
REQ-037 The pointer, tie-break and lock counter are one sub-module, rr_grant2; the arbiter top holds the muxes and the read-return pipeline.

Verification
REQ-038 After reset, m0 reads addr 0x005 where RAM[5] = 0x1234 -> m0_gnt in the same cycle, m0_rvalid=1 with m0_rdata=0x1234 one cycle later, m1_rvalid=0.
REQ-039 Both masters continuously request writes (m0 addr 0x010 data 0xAAAA, m1 addr 0x020 data 0x5555) -> grants alternate m0, m1, m0, m1 starting with m0.
REQ-040 m1 holds req=1 and lock=1 for 20 reads while m0 requests -> m1 gets exactly 16 consecutive grants, then m0 is granted.
REQ-041 m1 read of 0x7FF is followed immediately by an m0 read of 0x000 -> rvalid pulses go to m1 then m0 on consecutive cycles with the correct data, and no pulse reaches the wrong master.
REQ-042 Reset is asserted in the cycle an m0 read is granted -> no m0_rvalid afterwards, and all outputs are 0 while reset is high.
